mult_unit: RTL

- Iterative shift-add multiplier with architectural HI/LO registers, downstream of the instruction decoder.
- Executes multu; serves mfhi/mflo reads, selected by the decoder's 2-bit multcont (01 = HI, 10 = LO).
- Produces a stall to the datapath while a product is in flight.
- Trades the single-cycle combinational multiplier for WIDTH cycles of latency at far lower area.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_datapath.sv | 69 ++++++
 rtl/mult_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and encodings for the iterative multiplier
package mult_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MC_NONE = 2'b00;
  localparam logic [1:0] MC_HI   = 2'b01;
  localparam logic [1:0] MC_LO   = 2'b10;

  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = $clog2(MULT_WIDTH);

  // Iteration counter width for an arbitrary operand width, never below one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - operand/accumulator registers and shift-add step
// Optional MULT_SIGNED_EN: magnitude operands and sign-corrected product.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MULT_SIGNED_EN
  input  logic               sign,
`endif
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_q, mplier_q, op_a, op_b;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [WIDTH:0]     sum;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  always_comb begin
    op_a  = (sign && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
    op_b  = (sign && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
    neg_d = sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset)     neg_q <= 1'b0;
    else if (load) neg_q <= neg_d;
  end
`else
  assign op_a = srca;
  assign op_b = srcb;
`endif

  // The carry out of the upper-half add becomes the top bit after the shift.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_next = {sum, acc_q[WIDTH-1:1]};
  end

`ifdef MULT_SIGNED_EN
  assign product = neg_q ? (~acc_next + 1'b1) : acc_next;
`else
  assign product = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load) begin
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
    end else if (step) begin
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative shift-add multiplier with HI/LO and decoder stall
// Optional MULT_SIGNED_EN: adds the sign input for signed multiply.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MULT_SIGNED_EN
  input  logic             sign,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [1:0]       multcont,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               load, step, finish;
  logic [2*WIDTH-1:0] product;

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .reset   (reset),
`ifdef MULT_SIGNED_EN
    .sign    (sign),
`endif
    .load    (load),
    .step    (step),
    .srca    (srca),
    .srcb    (srcb),
    .product (product)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step    = 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          finish  = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // HI/LO change only on the completion edge, so partial products stay hidden.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= finish;
      if (finish) {hi_q, lo_q} <= product;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign stall = busy & (start | (multcont == MC_HI) | (multcont == MC_LO));

  always_comb begin
    result = '0;
    if (multcont == MC_HI)      result = hi_q;
    else if (multcont == MC_LO) result = lo_q;
  end

endmodule
